mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL expose parameter MEM_LATENCY, default 100: cycles from command-accept cycle to first response cycle.
REQ-002 SHALL expose parameter LINE_ADDR_W, default 15: line address width (10-bit tag + 5-bit set index).
REQ-003 SHALL expose parameter BEATS, default 8: 16-bit beats per 16-byte line.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 c2m_cmd  input  2  cache request: 0 NOP, 2 READ_LINE, 3 WRITE_LINE; 1 reserved and treated as NOP.
REQ-007 c2m_addr  input  LINE_ADDR_W  line address; sampled only on the accept cycle.
REQ-008 c2m_data  input  16  write beats, little-endian (line byte 2i in bits [7:0] of beat i).
REQ-009 m2c_cmd  output  2  response: 0 NOP, 1 RESPONSE.
REQ-010 m2c_data  output  16  read beats, same byte order as c2m_data.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL hold a backing array of 2^LINE_ADDR_W lines, each BEATS x 16 bits, zero-initialised at time 0.
REQ-013 SHALL implement FSM states IDLE, WR_RX, WAIT, RD_TX, WR_ACK.
REQ-014 IDLE: c2m_cmd=READ_LINE or WRITE_LINE accepts the request; latches c2m_addr; loads the latency counter with MEM_LATENCY-1.
REQ-015 On a WRITE_LINE accept, the accept cycle SHALL carry beat 0; beats 1..BEATS-1 SHALL be captured on the following BEATS-1 cycles (state WR_RX), with no stall option.
REQ-016 On a READ_LINE accept, the next state SHALL be WAIT; after WR_RX completes, the next state SHALL be WAIT.
REQ-017 The latency counter SHALL decrement every cycle from the accept cycle, including WR_RX cycles; the FSM SHALL leave WAIT when the counter reaches 0.
REQ-018 For a read, the FSM SHALL enter RD_TX; for a write, it SHALL enter WR_ACK.
REQ-019 The first response cycle SHALL occur exactly MEM_LATENCY cycles after the accept cycle (accept at edge t, m2c_cmd=RESPONSE first visible after edge t+MEM_LATENCY).
REQ-020 If MEM_LATENCY <= BEATS, the write response SHALL follow the last captured beat on the next cycle; actual latency becomes max(MEM_LATENCY, BEATS).
REQ-021 RD_TX: m2c_cmd=RESPONSE and m2c_data=beat i for BEATS consecutive cycles, i=0..BEATS-1; the FSM then returns to IDLE.
REQ-022 WR_ACK: the full line SHALL be committed to the array; m2c_cmd=RESPONSE for exactly 1 cycle with m2c_data=0; the FSM then returns to IDLE.
REQ-023 Outside response cycles, m2c_cmd SHALL be 0 and m2c_data SHALL be 0.
REQ-024 Any c2m_cmd while busy=1 SHALL be ignored and have no effect; c2m_data outside capture cycles SHALL be ignored.
REQ-025 A READ_LINE SHALL return the array contents at the time of its RD_TX, reflecting any write acknowledged earlier.
REQ-026 The first cycle after return to IDLE SHALL accept a new command (back-to-back, zero bubble).
REQ-027 Address wrap: line address 2^LINE_ADDR_W-1 SHALL be valid; no address arithmetic beyond indexing.

Reset
REQ-028 reset=1 at a clock edge SHALL force state IDLE, busy=0, m2c_cmd=0, m2c_data=0, counter=0, beat index=0.
REQ-029 A write aborted by reset before WR_ACK SHALL leave the array line unchanged; array contents SHALL otherwise survive reset.
REQ-030 A command presented on a cycle where reset=1 SHALL NOT be accepted.

Verification
REQ-031 Read of never-written line 0x0010 -> busy from the next cycle; 8 RESPONSE beats of 0x0000 starting exactly 100 cycles after accept.
REQ-032 WRITE_LINE to 0x4001, beats 0x1111..0x8888 -> one RESPONSE at +100 cycles; READ_LINE to 0x4001 issued on the following IDLE cycle -> beats 0x1111,0x2222,...,0x8888 in order.
REQ-033 READ_LINE to 0x0003 presented while busy (mid-write) -> ignored: exactly one response burst total, and no second burst.
REQ-034 Reset asserted during WR_RX of a write of 0xAAAA x8 to 0x0005 -> busy=0 and m2c_cmd=0 after the edge; a subsequent read of 0x0005 -> 8 beats of 0x0000.
REQ-035 MEM_LATENCY=4 override with a WRITE_LINE -> response 1 cycle after beat 7 (8 cycles after accept); a READ_LINE -> first beat at +4.
REQ-036 Writes to 0x0000 and 0x7FFF with distinct patterns, then reads of both -> each returns its own pattern; no aliasing at the top address.

Source files
------------

// File: rtl/mem_ctrl.sv
// Line-oriented memory controller: fixed-latency READ_LINE / WRITE_LINE against a
// backing array, with burst write capture and burst read response.
module mem_ctrl #(
  parameter int MEM_LATENCY = 100,
  parameter int LINE_ADDR_W = 15,
  parameter int BEATS       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             c2m_cmd,
  input  logic [LINE_ADDR_W-1:0] c2m_addr,
  input  logic [15:0]            c2m_data,
  output logic [1:0]             m2c_cmd,
  output logic [15:0]            m2c_data,
  output logic                   busy
);

  localparam int LINE_W = BEATS * 16;
  localparam int DEPTH  = 1 << LINE_ADDR_W;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;
  localparam logic [1:0] RSP_NOP   = 2'd0;
  localparam logic [1:0] RSP_RESP  = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_RX  = 3'd1,
    S_WAIT   = 3'd2,
    S_RD_TX  = 3'd3,
    S_WR_ACK = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic                       is_wr_q, is_wr_d;
  logic [LINE_ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_dec_s;
  logic [BIDX_W-1:0]          beat_q, beat_d, beat_nxt_s;
  logic [BEATS-1:0][15:0]     wbuf_q, wbuf_d;
  logic [1:0]                 m2c_cmd_q, m2c_cmd_d;
  logic [15:0]                m2c_data_q, m2c_data_d;
  logic                       mem_we_s;
  logic [LINE_W-1:0]          rd_line_s;

  // Power-up contents are zero (simulator zero-init / device memory init); reset never clears them.
  logic [LINE_W-1:0]          mem_q [DEPTH];

  assign rd_line_s  = mem_q[addr_q];
  assign cnt_dec_s  = (cnt_q != {CNT_W{1'b0}}) ? cnt_q - CNT_W'(1) : {CNT_W{1'b0}};
  assign beat_nxt_s = beat_q + BIDX_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    wbuf_d     = wbuf_q;
    m2c_cmd_d  = RSP_NOP;
    m2c_data_d = 16'h0000;
    mem_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c2m_cmd == CMD_READ || c2m_cmd == CMD_WRITE) begin
          addr_d = c2m_addr;
          cnt_d  = CNT_W'(MEM_LATENCY - 1);
          beat_d = {BIDX_W{1'b0}};
          if (c2m_cmd == CMD_WRITE) begin
            is_wr_d   = 1'b1;
            wbuf_d[0] = c2m_data;
            beat_d    = BIDX_W'(1);
            state_d   = (BEATS > 1) ? S_WR_RX : S_WAIT;
          end else begin
            is_wr_d = 1'b0;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_RX: begin
        wbuf_d[beat_q] = c2m_data;
        cnt_d          = cnt_dec_s;
        if (beat_q == BIDX_W'(BEATS - 1)) begin
          beat_d  = {BIDX_W{1'b0}};
          state_d = S_WAIT;
        end else begin
          beat_d = beat_nxt_s;
        end
      end
      S_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          m2c_cmd_d = RSP_RESP;
          beat_d    = {BIDX_W{1'b0}};
          if (is_wr_q) begin
            mem_we_s = 1'b1;
            state_d  = S_WR_ACK;
          end else begin
            m2c_data_d = rd_line_s[{{BIDX_W{1'b0}}, 4'b0000} +: 16];
            state_d    = S_RD_TX;
          end
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_RD_TX: begin
        if (beat_q == BIDX_W'(BEATS - 1)) begin
          beat_d  = {BIDX_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          beat_d     = beat_nxt_s;
          m2c_cmd_d  = RSP_RESP;
          m2c_data_d = rd_line_s[{beat_nxt_s, 4'b0000} +: 16];
        end
      end
      S_WR_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= {LINE_ADDR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      beat_q     <= {BIDX_W{1'b0}};
      wbuf_q     <= '0;
      m2c_cmd_q  <= RSP_NOP;
      m2c_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      wbuf_q     <= wbuf_d;
      m2c_cmd_q  <= m2c_cmd_d;
      m2c_data_q <= m2c_data_d;
    end
  end

  // Line commit on entry to WR_ACK; a reset on that edge aborts the write
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[addr_q] <= wbuf_q;
    end
  end

  assign m2c_cmd  = m2c_cmd_q;
  assign m2c_data = m2c_data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl: a default-latency instance and a
// MEM_LATENCY=4 instance share stimulus; a line-level array model predicts responses.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  c2m_cmd;
  logic [14:0] c2m_addr;
  logic [15:0] c2m_data;
  logic [1:0]  cmd_a, cmd_b;
  logic [15:0] data_a, data_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  logic [127:0] model_mem [int];
  logic [14:0]  pool [8];

  always #5 clk = ~clk;

  mem_ctrl dut_a (
    .clk(clk), .reset(reset), .c2m_cmd(c2m_cmd), .c2m_addr(c2m_addr), .c2m_data(c2m_data),
    .m2c_cmd(cmd_a), .m2c_data(data_a), .busy(busy_a)
  );

  mem_ctrl #(.MEM_LATENCY(4)) dut_b (
    .clk(clk), .reset(reset), .c2m_cmd(c2m_cmd), .c2m_addr(c2m_addr), .c2m_data(c2m_data),
    .m2c_cmd(cmd_b), .m2c_data(data_b), .busy(busy_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_beat(input logic [14:0] a, input int i);
    logic [127:0] line;
    line = 128'h0;
    if (model_mem.exists(int'(a))) line = model_mem[int'(a)];
    return line[i*16 +: 16];
  endfunction

  // One full transaction; checks the selected instance every cycle from accept to idle.
  task automatic run_txn(input bit sel4, input bit is_wr, input logic [14:0] addr,
                         input logic [127:0] line, input logic [14:0] noise_addr);
    int lat, first, n;
    logic [1:0]  ocmd;
    logic [15:0] odata;
    logic        obusy;
    bit          resp;
    lat   = sel4 ? 4 : 100;
    first = is_wr ? ((lat > 8) ? lat : 8) : lat;
    n     = is_wr ? 1 : 8;
    c2m_cmd  = is_wr ? 2'd3 : 2'd2;
    c2m_addr = addr;
    c2m_data = line[15:0];
    @(posedge clk); #1;
    for (int k = 0; k <= first + n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ocmd  = sel4 ? cmd_b  : cmd_a;
      odata = sel4 ? data_b : data_a;
      obusy = sel4 ? busy_b : busy_a;
      resp  = (k >= first) && (k < first + n);
      check_val(is_wr ? "wr_busy" : "rd_busy", {31'd0, obusy}, {31'd0, (k < first + n)});
      check_val(is_wr ? "wr_cmd" : "rd_cmd", {30'd0, ocmd}, resp ? 32'd1 : 32'd0);
      check_val(is_wr ? "wr_data" : "rd_data", {16'd0, odata},
                (resp && !is_wr) ? {16'd0, model_beat(addr, k - first)} : 32'd0);
      if (is_wr && (k + 1 < 8)) c2m_data = line[(k + 1) * 16 +: 16];
      else                      c2m_data = 16'($urandom);
      if ((k + 1 <= 8) && (k + 1 < first + n)) begin
        c2m_cmd  = 2'($urandom_range(0, 3));
        c2m_addr = noise_addr;
      end else begin
        c2m_cmd  = 2'd0;
        c2m_addr = 15'($urandom);
      end
    end
    if (is_wr) model_mem[int'(addr)] = line;
    c2m_cmd = 2'd0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((busy_a || busy_b) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("idle_timeout", {31'd0, (busy_a || busy_b)}, 32'd0);
  endtask

  initial begin
    logic [127:0] pat_a, pat_b, ln;
    pool = '{15'h0000, 15'h7FFF, 15'h0003, 15'h0005, 15'h4001, 15'h0010, 15'h1234, 15'h2AAA};
    reset    = 1'b1;
    c2m_cmd  = 2'd3;
    c2m_addr = 15'h0001;
    c2m_data = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check_val("rst_busy_b", {31'd0, busy_b}, 32'd0);
    check_val("rst_cmd_a", {30'd0, cmd_a}, 32'd0);
    check_val("rst_data_a", {16'd0, data_a}, 32'd0);
    reset   = 1'b0;
    c2m_cmd = 2'd0;
    @(posedge clk); #1;
    check_val("post_rst_busy", {31'd0, busy_a}, 32'd0);

    // Never-written line reads zero
    run_txn(1'b0, 1'b0, 15'h0010, 128'h0, 15'h0003);
    // Write then back-to-back read of the same line
    run_txn(1'b0, 1'b1, 15'h4001, 128'h8888_7777_6666_5555_4444_3333_2222_1111, 15'h0003);
    run_txn(1'b0, 1'b0, 15'h4001, 128'h0, 15'h0003);
    // Read of 0x0003 presented mid-write is ignored
    run_txn(1'b0, 1'b1, 15'h0007, {8{16'h0707}}, 15'h0003);
    wait_idle();

    // Reset during WR_RX aborts the write; command during reset is not accepted
    c2m_cmd  = 2'd3;
    c2m_addr = 15'h0005;
    c2m_data = 16'hAAAA;
    @(posedge clk); #1;
    c2m_cmd = 2'd0;
    repeat (2) begin @(posedge clk); #1; end
    reset   = 1'b1;
    c2m_cmd = 2'd2;
    @(posedge clk); #1;
    check_val("abort_busy_a", {31'd0, busy_a}, 32'd0);
    check_val("abort_busy_b", {31'd0, busy_b}, 32'd0);
    check_val("abort_cmd_a", {30'd0, cmd_a}, 32'd0);
    check_val("abort_cmd_b", {30'd0, cmd_b}, 32'd0);
    reset   = 1'b0;
    c2m_cmd = 2'd0;
    @(posedge clk); #1;
    check_val("abort_no_accept", {31'd0, busy_a}, 32'd0);
    run_txn(1'b0, 1'b0, 15'h0005, 128'h0, 15'h0000);

    // Bottom and top addresses hold distinct lines
    pat_a = {$urandom, $urandom, $urandom, $urandom};
    pat_b = ~pat_a;
    run_txn(1'b0, 1'b1, 15'h0000, pat_a, 15'h0001);
    run_txn(1'b0, 1'b1, 15'h7FFF, pat_b, 15'h0001);
    run_txn(1'b0, 1'b0, 15'h0000, 128'h0, 15'h7FFF);
    run_txn(1'b0, 1'b0, 15'h7FFF, 128'h0, 15'h0000);

    // Randomized traffic on the default-latency instance
    for (int i = 0; i < 20; i++) begin
      ln = {$urandom, $urandom, $urandom, $urandom};
      run_txn(1'b0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], ln,
              pool[$urandom_range(0, 7)]);
    end

    // Short-latency instance: write response after last beat, read at +4
    wait_idle();
    ln = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1'b1, 1'b1, 15'h1234, ln, 15'h0003);
    wait_idle();
    run_txn(1'b1, 1'b0, 15'h1234, 128'h0, 15'h0003);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      ln = {$urandom, $urandom, $urandom, $urandom};
      run_txn(1'b1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], ln,
              pool[$urandom_range(0, 7)]);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
